// File: rtl/vga_timing_detector.sv
// Receive-side VGA timing detector: measures hsync/vsync timing, locks to the
// configured mode and regenerates active-area flags and coordinates.
module vga_timing_detector #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    output logic        locked,
    output logic        active,
    output logic [9:0]  active_row,
    output logic [9:0]  active_col,
    output logic [10:0] line_clocks,
    output logic [10:0] hsync_width,
    output logic [10:0] frame_lines,
    output logic [10:0] vsync_width,
    output logic        sync_error
);
    localparam logic [10:0] TIMEOUT_COL = 11'(2 * TOTAL_COLS - 1);
    localparam logic [10:0] COL_FIRST   = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] COL_END     = 11'(H_SYNC + H_BACK + ACTIVE_COLS);
    localparam logic [10:0] ROW_FIRST   = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] ROW_END     = 11'(V_SYNC + V_BACK + ACTIVE_ROWS);

    typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

    state_t      state, state_next;
    logic        hsync_q, vsync_q, pend;
    logic [10:0] col, row, hlow, vcnt;
    logic        h_fall, h_rise, v_fall, frame_start;
    logic        line_ok, frame_ok, mismatch, timeout, err_next;

    function automatic logic [10:0] sat_inc(input logic [10:0] x);
        return (x == 11'h7ff) ? x : x + 11'd1;
    endfunction

    assign h_fall      = hsync_q & ~hsync;
    assign h_rise      = ~hsync_q & hsync;
    assign v_fall      = vsync_q & ~vsync;
    assign frame_start = h_fall & (pend | v_fall);

    // Checks are evaluated on the edge that closes the interval, so the
    // resulting state and error are visible in the line-start cycle.
    assign line_ok  = (sat_inc(col) == 11'(TOTAL_COLS)) && (hsync_width == 11'(H_SYNC));
    assign frame_ok = (sat_inc(row) == 11'(TOTAL_ROWS)) && (vcnt == 11'(V_SYNC));
    assign mismatch = h_fall & (~line_ok | (frame_start & ~frame_ok));
    assign timeout  = ~h_fall & (col == TIMEOUT_COL);

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            pend        <= 1'b0;
            col         <= '0;
            row         <= '0;
            hlow        <= '0;
            vcnt        <= '0;
            line_clocks <= '0;
            hsync_width <= '0;
            frame_lines <= '0;
            vsync_width <= '0;
        end else begin
            hsync_q <= hsync;
            vsync_q <= vsync;
            col     <= h_fall ? 11'd0 : sat_inc(col);
            if (h_fall)
                hlow <= 11'd1;
            else if (~hsync)
                hlow <= sat_inc(hlow);
            if (h_rise)
                hsync_width <= hlow;
            if (frame_start)
                pend <= 1'b0;
            else if (v_fall)
                pend <= 1'b1;
            if (h_fall) begin
                line_clocks <= sat_inc(col);
                if (frame_start) begin
                    row         <= '0;
                    frame_lines <= sat_inc(row);
                    vsync_width <= vcnt;
                    vcnt        <= ~vsync ? 11'd1 : 11'd0;
                end else begin
                    row <= sat_inc(row);
                    if (~vsync)
                        vcnt <= sat_inc(vcnt);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_SEARCH;
            sync_error <= 1'b0;
        end else begin
            state      <= state_next;
            sync_error <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        case (state)
            ST_SEARCH:  if (frame_start) state_next = ST_MEASURE;
            ST_MEASURE: begin
                if (timeout | mismatch)
                    state_next = ST_SEARCH;
                else if (frame_start)
                    state_next = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (timeout | mismatch) begin
                    state_next = ST_SEARCH;
                    err_next   = 1'b1;
                end
            end
            default: state_next = ST_SEARCH;
        endcase
    end

    always_comb begin
        locked     = (state == ST_LOCKED);
        active     = locked && (col >= COL_FIRST) && (col < COL_END)
                            && (row >= ROW_FIRST) && (row < ROW_END);
        active_col = '0;
        active_row = '0;
        if (active) begin
            active_col = 10'(col - COL_FIRST);
            active_row = 10'(row - ROW_FIRST);
        end
    end
endmodule
